// File: rtl/mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_port_arbiter (with mem_port_arbiter_pkg)
// Brief    : Round-robin arbiter sharing one main-memory port between N caches.
// Revision : 1.0 - initial release
//==============================================================================

package mem_port_arbiter_pkg;
    localparam int ADDR_W     = 32;
    localparam int BLOCK_SIZE = 8;

    typedef struct packed {
        logic                       cs;
        logic                       rw;
        logic [ADDR_W-1:0]          addr;
        logic [BLOCK_SIZE-1:0][7:0] data;
    } memory_request_t;

    typedef struct packed {
        logic                       ack;
        logic [BLOCK_SIZE-1:0][7:0] data;
    } memory_response_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  memory_request_t    cache_req [N_PORTS],
    output memory_response_t   cache_res [N_PORTS],
    output memory_request_t    mem_req,
    input  memory_response_t   mem_res,
    output logic [N_PORTS-1:0] grant,
    output logic               busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [PTR_W-1:0] c_last_rst = PTR_W'(N_PORTS - 1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_gnt_idx;
    logic [PTR_W-1:0]   r_last_idx;
    logic [N_PORTS-1:0] r_grant;

    logic               w_any_req;
    logic [PTR_W-1:0]   w_winner;
    logic               w_gnt_cs;

    // Search starts one past the previous winner, so that port ranks last.
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            if (!w_any_req && cache_req[(int'(r_last_idx) + k) % N_PORTS].cs) begin
                w_any_req = 1'b1;
                w_winner  = PTR_W'((int'(r_last_idx) + k) % N_PORTS);
            end
        end
    end

    assign w_gnt_cs = cache_req[r_gnt_idx].cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= '0;
            r_last_idx <= c_last_rst;
            r_grant    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ST_BUSY;
                        r_gnt_idx <= w_winner;
                        r_grant   <= N_PORTS'(1) << w_winner;
                    end
                end
                ST_BUSY: begin
                    if (mem_res.ack) begin
                        r_state    <= ST_IDLE;
                        r_last_idx <= r_gnt_idx;
                        r_grant    <= '0;
                    end else if (!w_gnt_cs) begin
                        // Abandoned: the pointer stays put so the port keeps its turn.
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Request and response are routed, not latched: the owner holds its request until ack.
    always_comb begin
        mem_req = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            cache_res[j] = '0;
        end
        if (r_state == ST_BUSY) begin
            mem_req              = cache_req[r_gnt_idx];
            cache_res[r_gnt_idx] = mem_res;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomised self-checking bench with a behavioural arbiter model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = BLOCK_SIZE * 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    memory_request_t  cache_req [N];
    memory_response_t cache_res [N];
    memory_request_t  mem_req;
    memory_response_t mem_res;
    logic [N-1:0]     grant;
    logic             busy;

    int tests = 0;
    int fails = 0;

    bit          seen_ack [N];
    int          mem_cnt    = 0;
    int          mem_delay  = 0;
    int          delay_lo   = 0;
    int          delay_hi   = 0;
    bit          fixed_data = 1'b0;
    logic [DW-1:0] fixed_val = '0;

    mem_port_arbiter #(.N_PORTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cache_req (cache_req),
        .cache_res (cache_res),
        .mem_req   (mem_req),
        .mem_res   (mem_res),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: owner index (-1 = none), last winner
    int           m_owner = -1;
    int           m_last  = N - 1;
    logic [N-1:0] req_cs;

    always_comb begin
        for (int i = 0; i < N; i++) req_cs[i] = cache_req[i].cs;
    end

    function automatic int rr_pick(input int last, input logic [N-1:0] cs);
        int pick;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            if (pick < 0 && cs[(last + k) % N]) pick = (last + k) % N;
        end
        return pick;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= N - 1;
        end else if (m_owner < 0) begin
            m_owner <= rr_pick(m_last, req_cs);
        end else if (mem_res.ack) begin
            m_last  <= m_owner;
            m_owner <= -1;
        end else if (!req_cs[m_owner]) begin
            m_owner <= -1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] acks();
        logic [N-1:0] a;
        for (int i = 0; i < N; i++) a[i] = cache_res[i].ack;
        return a;
    endfunction

    // ---------------- per-cycle comparison against the model
    logic [N-1:0]     e_grant;
    memory_request_t  e_req;
    memory_response_t e_res;

    always @(negedge clk) begin
        e_grant = '0;
        e_req   = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_req            = cache_req[m_owner];
        end
        check("grant", grant, e_grant);
        check("busy", busy, m_owner >= 0);
        check("mem_req", mem_req, e_req);
        for (int j = 0; j < N; j++) begin
            e_res = (j == m_owner) ? mem_res : '0;
            check($sformatf("cache_res[%0d]", j), cache_res[j], e_res);
        end
    end

    // ---------------- stimulus helpers
    function automatic logic [DW-1:0] rand_block();
        logic [DW-1:0] b;
        for (int i = 0; i < BLOCK_SIZE; i++) b[i*8 +: 8] = 8'($urandom);
        return b;
    endfunction

    function automatic memory_request_t rand_req(input logic rw);
        memory_request_t r;
        r.cs   = 1'b1;
        r.rw   = rw;
        r.addr = ADDR_W'($urandom);
        r.data = rand_block();
        return r;
    endfunction

    // One clock cycle: caches update at +1, memory responds at +2, acks sampled at +3.
    task automatic step(input int req_pct, input int abandon_pct, input int spur_pct);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (seen_ack[i] || (cache_req[i].cs && grant[i] &&
                                int'($urandom_range(99)) < abandon_pct))
                cache_req[i] = '0;
            else if (!cache_req[i].cs && int'($urandom_range(99)) < req_pct)
                cache_req[i] = rand_req(1'($urandom_range(1)));
        end
        #1;
        mem_res = '0;
        if (mem_req.cs) begin
            if (mem_cnt >= mem_delay) begin
                mem_res.ack  = 1'b1;
                mem_res.data = fixed_data ? fixed_val : rand_block();
                mem_cnt      = 0;
                mem_delay    = int'($urandom_range(delay_hi, delay_lo));
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
            if (int'($urandom_range(99)) < spur_pct) begin
                mem_res.ack  = 1'b1;
                mem_res.data = rand_block();
            end
        end
        #1;
        for (int i = 0; i < N; i++) seen_ack[i] = cache_res[i].ack;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_grant", grant, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_cs", mem_req.cs, 1'b0);
        check("rst_acks", acks(), '0);
        for (int i = 0; i < N; i++) begin
            cache_req[i] = '0;
            seen_ack[i]  = 1'b0;
        end
        mem_res = '0;
        mem_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_delay(input int lo, input int hi);
        delay_lo  = lo;
        delay_hi  = hi;
        mem_delay = lo;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int              waited;
        logic [N-1:0]    ack3;
        logic [N-1:0]    order [$];
        int              gaps  [$];
        bit              prev_busy;
        int              idle_run;
        memory_request_t wb;
        logic [N-1:0]    exp_order [5];

        for (int i = 0; i < N; i++) begin
            cache_req[i] = '0;
            seen_ack[i]  = 1'b0;
        end
        mem_res = '0;

        // Reset, then stay idle with no requests.
        do_reset();
        set_delay(0, 0);
        repeat (4) step(0, 0, 0);
        check("idle_busy", busy, 1'b0);

        // Single read on port 2, memory acks 3 cycles after seeing cs.
        fixed_data = 1'b1;
        fixed_val  = {BLOCK_SIZE{8'hA5}};
        set_delay(3, 3);
        cache_req[2]      = '0;
        cache_req[2].cs   = 1'b1;
        cache_req[2].addr = 32'h40;
        step(0, 0, 0);
        check("read_grant", grant, 4'b0100);
        check("read_addr", mem_req.addr, 32'h40);
        check("read_rw", mem_req.rw, 1'b0);
        waited = 0;
        while (!seen_ack[2] && waited < 10) begin
            step(0, 0, 0);
            waited++;
        end
        check("read_latency", waited, 3);
        check("read_acks", acks(), 4'b0100);
        check("read_data", cache_res[2].data, {BLOCK_SIZE{8'hA5}});
        step(0, 0, 0);
        check("read_idle_after", busy, 1'b0);
        fixed_data = 1'b0;

        // Round-robin with all four ports requesting continuously.
        do_reset();
        set_delay(2, 2);
        for (int i = 0; i < N; i++) cache_req[i] = rand_req(1'b0);
        prev_busy = 1'b0;
        idle_run  = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            step(100, 0, 0);
            if (busy && !prev_busy) begin
                order.push_back(grant);
                if (order.size() > 1) gaps.push_back(idle_run);
            end
            idle_run  = busy ? 0 : idle_run + 1;
            prev_busy = busy;
        end
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("rr_order[%0d]", i), order[i], exp_order[i]);
        for (int i = 0; i < gaps.size(); i++)
            check($sformatf("rr_gap[%0d]", i), gaps[i], 1);

        // Write-back from port 1 with port 3 waiting.
        do_reset();
        set_delay(2, 2);
        wb           = rand_req(1'b1);
        cache_req[1] = wb;
        cache_req[3] = rand_req(1'b0);
        step(0, 0, 0);
        check("wb_grant", grant, 4'b0010);
        check("wb_rw", mem_req.rw, 1'b1);
        check("wb_data", mem_req.data, wb.data);
        ack3   = '0;
        waited = 0;
        while (!seen_ack[1] && waited < 10) begin
            step(0, 0, 0);
            ack3 |= acks() & 4'b1000;
            waited++;
        end
        check("wb_port3_held", ack3, '0);
        step(0, 0, 0);
        check("wb_dead_cycle", busy, 1'b0);
        step(0, 0, 0);
        check("wb_next_grant", grant, 4'b1000);

        // Reset in the middle of a port 3 transaction.
        do_reset();
        set_delay(10, 10);
        cache_req[3] = rand_req(1'b0);
        step(0, 0, 0);
        check("midrst_grant", grant, 4'b1000);
        step(0, 0, 0);
        do_reset();
        cache_req[0] = rand_req(1'b0);
        cache_req[3] = rand_req(1'b1);
        step(0, 0, 0);
        check("midrst_first", grant, 4'b0001);

        // Spurious ack while idle.
        do_reset();
        step(0, 0, 0);
        mem_res.ack  = 1'b1;
        mem_res.data = rand_block();
        #1;
        check("spur_acks", acks(), '0);
        step(0, 0, 0);
        check("spur_busy", busy, 1'b0);

        // Abandoned transaction leaves the pointer untouched.
        do_reset();
        set_delay(10, 10);
        cache_req[2] = rand_req(1'b0);
        step(0, 0, 0);
        check("abandon_grant", grant, 4'b0100);
        step(0, 0, 0);
        cache_req[2] = '0;
        step(0, 0, 0);
        check("abandon_idle", busy, 1'b0);
        cache_req[1] = rand_req(1'b0);
        cache_req[3] = rand_req(1'b0);
        step(0, 0, 0);
        check("abandon_last_idx", grant, 4'b0010);

        // Randomised traffic with spurious acks, abandonment and resets.
        do_reset();
        set_delay(0, 4);
        for (int c = 0; c < 3000; c++) begin
            step(25, 3, 10);
            if ($urandom_range(299) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one main-memory port between `N_PORTS` cache controllers. Each cache issues block-level allocate and write-back requests as `memory_request_t` and waits for `memory_response_t.ack`. The arbiter grants the memory port to one cache at a time and routes the response only to the granted cache. It sits between the per-core caches and the single memory model/controller.

## Interface

Parameters:
- `N_PORTS`, default 4: number of cache requesters, at least 2.
- `PTR_W`, default `$clog2(N_PORTS)`: width of the grant index.

Ports:
- `clk`  input  1: clock. All state changes on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `cache_req[N_PORTS]`  input  `memory_request_t`: per-cache request (`cs`, `rw`, `addr`, `data[BLOCK_SIZE]`).
- `cache_res[N_PORTS]`  output  `memory_response_t`: per-cache response (`ack`, `data`).
- `mem_req`  output  `memory_request_t`: request to memory.
- `mem_res`  input  `memory_response_t`: response from memory.
- `grant`  output  `N_PORTS`: one-hot grant. All zero when no port is granted.
- `busy`  output  1: high while a transaction is owned (state BUSY).

## Operation

State machine with two states, IDLE and BUSY, plus registers `gnt_idx` (`PTR_W`) and `last_idx` (`PTR_W`).

IDLE:
- `grant` = 0.
- `mem_req` is all zero (`cs`=0, `rw`=0, `addr`=0, data=0).
- All `cache_res` are zero.
- If any `cache_req[i].cs`=1, select the winner by round-robin: search from `last_idx+1`, wrapping modulo `N_PORTS`. The first port with `cs`=1 wins.
- On the edge: `gnt_idx` <= winner, go to BUSY.

BUSY:
- `mem_req` = `cache_req[gnt_idx]`, passed through combinationally with all fields.
- `cache_res[gnt_idx]` = `mem_res`, combinational.
- Every other `cache_res[j]` is `ack`=0, data=0.
- `grant[gnt_idx]`=1.
- If `mem_res.ack`=1: `last_idx` <= `gnt_idx`, go to IDLE.
- If `cache_req[gnt_idx].cs`=0 and `mem_res.ack`=0 (requester abandoned): go to IDLE and leave `last_idx` unchanged.
- Otherwise stay in BUSY. There is no timeout.

Rules:
- The request is not latched. The granted cache must hold `cs`/`rw`/`addr`/`data` stable until `ack`. Caches drop `cs` combinationally in the `ack` cycle, which is legal.
- Non-granted requesters keep `cs` asserted and are never acked. No request is dropped.
- Only one transaction is outstanding at a time.
- `mem_res.ack` while in IDLE is ignored and is not forwarded to any port.

Reset (asserted asynchronously, at any time, including mid-transaction):
- State = IDLE, `gnt_idx`=0, `last_idx`=`N_PORTS-1`, so port 0 has first priority.
- Outputs immediately: `grant`=0, `busy`=0, `mem_req.cs`=0, all `cache_res.ack`=0.
- An interrupted transaction is not resumed. The cache is reset by the same `rst`.

## Timing

- Grant latency: requester `cs` rises in IDLE cycle t. `grant`/`busy`/`mem_req.cs` become visible in cycle t+1.
- Response path: `mem_res` to `cache_res[gnt_idx]` is zero-cycle combinational.
- Release: `ack` in cycle k puts the block in IDLE at cycle k+1. A pending requester is granted, with `mem_req.cs`=1, at cycle k+2. This gives one dead cycle between transactions.
- Fairness: a continuously requesting port waits at most `N_PORTS-1` transactions.
- Simultaneous requests arriving in the same cycle are resolved purely by the round-robin pointer.

## Test plan

Run with `N_PORTS`=4.

1. Reset then idle.
   - Stimulus: assert `rst` mid-cycle.
   - Required: `grant`=0, `busy`=0, `mem_req.cs`=0 asynchronously. After release, with no requests, state stays IDLE.
2. Single read.
   - Stimulus: port 2 drives `cs`=1, `rw`=0, `addr`=0x40. Memory acks 3 cycles after seeing `cs` with data pattern 0xA5.
   - Required: `grant`=4'b0100 one cycle after the request. `mem_req.addr`=0x40. `cache_res[2]` gets `ack`=1 with the data. Ports 0, 1 and 3 see `ack`=0. IDLE the cycle after `ack`.
3. Round-robin.
   - Stimulus: after reset, ports 0–3 all request continuously. Memory acks each transaction after 2 cycles.
   - Required: grant order 0,1,2,3,0. Exactly one dead IDLE cycle between grants.
4. Write-back pass-through.
   - Stimulus: port 1 drives `rw`=1 with a full block.
   - Required: `mem_req.data` equals the port 1 block byte-for-byte. Port 3, requesting concurrently, is held with no `ack` until port 1 completes, then granted next.
5. Reset mid-transaction.
   - Stimulus: assert `rst` in BUSY while port 3 is granted, before `ack`.
   - Required: `mem_req.cs`=0 and `grant`=0 in the same cycle. After reset, simultaneous requests from ports 0 and 3 grant port 0 first.
6. Spurious and abandoned.
   - Stimulus (a): memory asserts `ack` while in IDLE. Required: no `cache_res.ack` asserted.
   - Stimulus (b): the granted port drops `cs` without `ack`. Required: back to IDLE next cycle, and `last_idx` is unchanged.
